exc_flush_ctrl: RTL and testbench
=================================

EXC_FLUSH_CTRL -- requirements
Module: exc_flush_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports named clk and reset.
REQ-002 Parameter EX_ENTRY, default 32'hbfc00380: exception vector PC.
REQ-003 Parameter FLUSH_CYCLES, default 1: cycles flush stays high per event, legal range 1..7.
REQ-004 clk  in  1  pipeline clock.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 ws_ex  in  1  WB-stage exception, already qualified by ws_valid.
REQ-007 ws_eret  in  1  WB-stage eret, already qualified by ws_valid.
REQ-008 cp0_epc  in  32  CP0 EPC value.
REQ-009 cp0_status  in  32  CP0 Status; bit0 is IE, bit1 is EXL, bits 15:8 are IM.
REQ-010 cp0_cause  in  32  CP0 Cause; bits 15:8 are IP.
REQ-011 flush  out  1  clears the valid bits of all pipeline stages.
REQ-012 redirect_valid  out  1  new fetch PC offered to pre-IF.
REQ-013 redirect_pc  out  32  redirect target.
REQ-014 redirect_ready  in  1  pre-IF accepts redirect_pc this cycle.
REQ-015 int_req  out  1  registered interrupt request, used by ID to tag its next instruction.
REQ-016 busy  out  1  high in any state other than IDLE.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, FLUSH and REDIRECT.
REQ-018 In IDLE, a rising clk edge with ws_ex or ws_eret high SHALL move the FSM to FLUSH, capture the target, and load the flush counter with FLUSH_CYCLES.
REQ-019 Target capture SHALL be: ws_ex gives EX_ENTRY; ws_eret alone gives cp0_epc as sampled at that edge.
REQ-020 If ws_ex and ws_eret are high together, ws_ex SHALL take priority and the target SHALL be EX_ENTRY.
REQ-021 flush SHALL be 1 in every FLUSH cycle and 0 in all other states.
REQ-022 The counter SHALL decrement once per FLUSH cycle; when it reaches 1, the next edge SHALL move the FSM to REDIRECT.
REQ-023 In REDIRECT, redirect_valid SHALL be 1 and redirect_pc SHALL equal the captured target, held stable until handshake.
REQ-024 The edge with redirect_valid and redirect_ready both high SHALL return the FSM to IDLE.
REQ-025 The redirect handshake SHALL NOT complete at any edge where redirect_ready is low.
REQ-026 ws_ex and ws_eret SHALL be ignored in FLUSH and REDIRECT; the captured target SHALL NOT change there.
REQ-027 Event-to-flush latency SHALL be 1 cycle: flush goes high in the cycle after the sampling edge.
REQ-028 Minimum event-to-redirect_valid latency SHALL be FLUSH_CYCLES+1 cycles.
REQ-029 int_pending SHALL be defined as: |(cp0_cause[15:8] & cp0_status[15:8]) && IE && !EXL.
REQ-030 int_req SHALL register (int_pending && FSM in IDLE && !ws_ex && !ws_eret) on every edge.
REQ-031 int_req SHALL be forced to 0 in the cycle after any event is accepted and for the whole time busy is high.
REQ-032 redirect_pc SHALL hold its last value when redirect_valid is 0; that value is not checked.

Reset
REQ-033 Asserting reset SHALL immediately, without waiting for clk, set: FSM to IDLE, counter to 0, flush 0, redirect_valid 0, redirect_pc 32'h0, int_req 0, busy 0.
REQ-034 A reset arriving in FLUSH or REDIRECT SHALL abandon the pending redirect; the block SHALL then take no action until the first event after reset release.

Structure
REQ-035 Shared package mycpu_ctrl_pkg SHALL hold: the FSM state encoding, the EX_ENTRY default, and the Status/Cause bit-position constants (IE=0, EXL=1, IM/IP=15:8).
REQ-036 The sub-module exc_int_detect SHALL hold the int_pending logic and the int_req register; everything else SHALL be in exc_flush_ctrl.

Verification
REQ-037 With FLUSH_CYCLES=1, pulse ws_ex for one cycle and hold redirect_ready=1 -> flush high exactly 1 cycle at T+1; redirect_valid high at T+2 with redirect_pc=32'hbfc00380; busy low at T+3.
REQ-038 With cp0_epc=32'hbfc00124, pulse ws_eret and hold redirect_ready=0 for 4 cycles -> redirect_valid and redirect_pc=32'hbfc00124 held stable across all 4 cycles; return to IDLE on the edge where redirect_ready=1.
REQ-039 Assert ws_ex=1 and ws_eret=1 together with cp0_epc=32'h1000 -> redirect_pc=32'hbfc00380; after that event, exactly one flush pulse has occurred.
REQ-040 With FLUSH_CYCLES=3, pulse ws_ex, then pulse ws_eret during FLUSH -> flush high 3 cycles; the single redirect targets 32'hbfc00380; the eret is ignored.
REQ-041 Set Status=32'h0000_0401 and Cause=32'h0000_0400 -> int_req=1 one cycle later; then set Status bit1 (EXL)=1 -> int_req=0 one cycle later; assert ws_ex -> int_req stays 0 while busy.
REQ-042 Assert reset mid-REDIRECT -> flush, redirect_valid and int_req are 0 before the next clk edge; after release, no redirect occurs without a new event.

Source files
------------

// File: rtl/mycpu_ctrl_pkg.sv
// Shared control definitions for the exception/flush controller: FSM encoding,
// exception vector default and CP0 Status/Cause field positions.
package mycpu_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StFlush,
        StRedirect
    } ctrl_state_e;

    localparam logic [31:0] EX_ENTRY_DEFAULT = 32'hbfc00380;

    localparam int unsigned STATUS_IE_BIT  = 0;
    localparam int unsigned STATUS_EXL_BIT = 1;
    localparam int unsigned IM_IP_HI       = 15;
    localparam int unsigned IM_IP_LO       = 8;

endpackage

// File: rtl/exc_int_detect.sv
// Interrupt pending detection and the registered int_req handed to ID.
module exc_int_detect
    import mycpu_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] cp0_status,
    input  logic [31:0] cp0_cause,
    input  logic        idle,
    input  logic        ws_ex,
    input  logic        ws_eret,
    output logic        int_req
);

    logic int_pending;
    logic int_req_d;
    logic int_req_q;
    logic unused_bits;

    assign int_pending = (|(cp0_cause[IM_IP_HI:IM_IP_LO] & cp0_status[IM_IP_HI:IM_IP_LO]))
                         && cp0_status[STATUS_IE_BIT] && !cp0_status[STATUS_EXL_BIT];

    // Suppressed on the accepting edge and throughout any busy period.
    assign int_req_d = int_pending && idle && !ws_ex && !ws_eret;

    assign unused_bits = ^{cp0_status[31:16], cp0_status[7:2], cp0_cause[31:16], cp0_cause[7:0]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            int_req_q <= 1'b0;
        end else begin
            int_req_q <= int_req_d;
        end
    end

    assign int_req = int_req_q;

endmodule

// File: rtl/exc_flush_ctrl.sv
// WB-stage exception/eret handler: flushes the pipeline for FLUSH_CYCLES cycles,
// then offers the captured target PC to pre-IF until it is accepted.
module exc_flush_ctrl
    import mycpu_ctrl_pkg::*;
#(
    parameter logic [31:0] EX_ENTRY     = EX_ENTRY_DEFAULT,
    parameter int unsigned FLUSH_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ws_ex,
    input  logic        ws_eret,
    input  logic [31:0] cp0_epc,
    input  logic [31:0] cp0_status,
    input  logic [31:0] cp0_cause,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    input  logic        redirect_ready,
    output logic        int_req,
    output logic        busy
);

    localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES);

    ctrl_state_e state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] target_q, target_d;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        target_d       = target_q;
        flush          = 1'b0;
        redirect_valid = 1'b0;
        case (state_q)
            StIdle: begin
                if (ws_ex || ws_eret) begin
                    state_d  = StFlush;
                    cnt_d    = FLUSH_INIT;
                    // Exception wins over a simultaneous eret.
                    target_d = ws_ex ? EX_ENTRY : cp0_epc;
                end
            end
            StFlush: begin
                flush = 1'b1;
                if (cnt_q <= 3'd1) begin
                    state_d = StRedirect;
                    cnt_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            StRedirect: begin
                redirect_valid = 1'b1;
                if (redirect_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            cnt_q    <= 3'd0;
            target_q <= 32'h0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            target_q <= target_d;
        end
    end

    assign redirect_pc = target_q;
    assign busy        = (state_q != StIdle);

    exc_int_detect u_int_detect (
        .clk        (clk),
        .reset      (reset),
        .cp0_status (cp0_status),
        .cp0_cause  (cp0_cause),
        .idle       (state_q == StIdle),
        .ws_ex      (ws_ex),
        .ws_eret    (ws_eret),
        .int_req    (int_req)
    );

endmodule

// File: tb/tb_exc_flush_ctrl.sv
// Directed bench for exc_flush_ctrl with FLUSH_CYCLES=1 and FLUSH_CYCLES=3 instances.
module tb_exc_flush_ctrl;

    logic        clk;
    logic        reset;
    logic        ws_ex;
    logic        ws_eret;
    logic [31:0] cp0_epc;
    logic [31:0] cp0_status;
    logic [31:0] cp0_cause;
    logic        redirect_ready;

    logic        flush1, rv1, int_req1, busy1;
    logic [31:0] pc1;
    logic        flush3, rv3, int_req3, busy3;
    logic [31:0] pc3;

    int checks = 0;
    int errors = 0;

    exc_flush_ctrl #(.FLUSH_CYCLES(1)) u_dut1 (
        .clk            (clk),
        .reset          (reset),
        .ws_ex          (ws_ex),
        .ws_eret        (ws_eret),
        .cp0_epc        (cp0_epc),
        .cp0_status     (cp0_status),
        .cp0_cause      (cp0_cause),
        .flush          (flush1),
        .redirect_valid (rv1),
        .redirect_pc    (pc1),
        .redirect_ready (redirect_ready),
        .int_req        (int_req1),
        .busy           (busy1)
    );

    exc_flush_ctrl #(.FLUSH_CYCLES(3)) u_dut3 (
        .clk            (clk),
        .reset          (reset),
        .ws_ex          (ws_ex),
        .ws_eret        (ws_eret),
        .cp0_epc        (cp0_epc),
        .cp0_status     (cp0_status),
        .cp0_cause      (cp0_cause),
        .flush          (flush3),
        .redirect_valid (rv3),
        .redirect_pc    (pc3),
        .redirect_ready (redirect_ready),
        .int_req        (int_req3),
        .busy           (busy3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
    endtask

    int nflush, nrv, first_rv, bound;
    logic [31:0] got_pc;

    initial begin
        reset = 1'b1; ws_ex = 1'b0; ws_eret = 1'b0; cp0_epc = 32'h0;
        cp0_status = 32'h0; cp0_cause = 32'h0; redirect_ready = 1'b1;
        step();
        check_eq("rst_flush", {31'b0, flush1}, 32'd0);
        check_eq("rst_rv", {31'b0, rv1}, 32'd0);
        check_eq("rst_busy", {31'b0, busy1}, 32'd0);
        check_eq("rst_int_req", {31'b0, int_req1}, 32'd0);
        check_eq("rst_pc", pc1, 32'h0);
        reset = 1'b0;
        step();

        // ws_ex pulse, ready held high
        ws_ex = 1'b1;
        step();
        ws_ex = 1'b0;
        check_eq("ex_flush_t1", {31'b0, flush1}, 32'd1);
        check_eq("ex_rv_t1", {31'b0, rv1}, 32'd0);
        check_eq("ex_busy_t1", {31'b0, busy1}, 32'd1);
        step();
        check_eq("ex_flush_t2", {31'b0, flush1}, 32'd0);
        check_eq("ex_rv_t2", {31'b0, rv1}, 32'd1);
        check_eq("ex_pc_t2", pc1, 32'hbfc00380);
        step();
        check_eq("ex_busy_t3", {31'b0, busy1}, 32'd0);
        check_eq("ex_rv_t3", {31'b0, rv1}, 32'd0);

        // eret with redirect back-pressure
        do_reset();
        cp0_epc = 32'hbfc00124;
        ws_eret = 1'b1;
        redirect_ready = 1'b0;
        step();
        ws_eret = 1'b0;
        cp0_epc = 32'h0;
        check_eq("eret_flush", {31'b0, flush1}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            step();
            check_eq("eret_hold_rv", {31'b0, rv1}, 32'd1);
            check_eq("eret_hold_pc", pc1, 32'hbfc00124);
        end
        redirect_ready = 1'b1;
        step();
        check_eq("eret_done_busy", {31'b0, busy1}, 32'd0);

        // simultaneous ex and eret
        do_reset();
        cp0_epc = 32'h1000;
        ws_ex = 1'b1;
        ws_eret = 1'b1;
        nflush = 0; nrv = 0; got_pc = 32'h0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (i == 0) begin
                ws_ex = 1'b0;
                ws_eret = 1'b0;
            end
            if (flush1) nflush++;
            if (rv1) begin
                nrv++;
                got_pc = pc1;
            end
        end
        check_eq("both_nflush", nflush, 32'd1);
        check_eq("both_nrv", nrv, 32'd1);
        check_eq("both_pc", got_pc, 32'hbfc00380);

        // FLUSH_CYCLES=3, eret during flush ignored
        do_reset();
        ws_ex = 1'b1;
        nflush = 0; nrv = 0; first_rv = -1; got_pc = 32'h0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (i == 0) begin
                ws_ex = 1'b0;
                check_eq("fc3_flush_latency", {31'b0, flush3}, 32'd1);
            end
            if (i == 1) begin
                ws_eret = 1'b1;
                cp0_epc = 32'h1234;
            end
            if (i == 2) ws_eret = 1'b0;
            if (flush3) nflush++;
            if (rv3) begin
                nrv++;
                got_pc = pc3;
                if (first_rv < 0) first_rv = i;
            end
        end
        check_eq("fc3_nflush", nflush, 32'd3);
        check_eq("fc3_nrv", nrv, 32'd1);
        check_eq("fc3_pc", got_pc, 32'hbfc00380);
        check_eq("fc3_rv_latency", first_rv, 32'd3);

        // interrupt request gating
        do_reset();
        cp0_status = 32'h0000_0401;
        cp0_cause = 32'h0000_0400;
        check_eq("int_before", {31'b0, int_req1}, 32'd0);
        step();
        check_eq("int_set", {31'b0, int_req1}, 32'd1);
        cp0_status = 32'h0000_0403;
        step();
        check_eq("int_exl", {31'b0, int_req1}, 32'd0);
        cp0_status = 32'h0000_0401;
        step();
        check_eq("int_reset_again", {31'b0, int_req1}, 32'd1);
        ws_ex = 1'b1;
        step();
        ws_ex = 1'b0;
        check_eq("int_accept_edge", {31'b0, int_req1}, 32'd0);
        check_eq("int_accept_busy", {31'b0, busy1}, 32'd1);
        bound = 0;
        while (busy1 && bound < 10) begin
            step();
            bound++;
            if (busy1) check_eq("int_while_busy", {31'b0, int_req1}, 32'd0);
        end
        check_eq("int_busy_bound", {31'b0, busy1}, 32'd0);
        step();
        check_eq("int_after_idle", {31'b0, int_req1}, 32'd1);

        // asynchronous reset in REDIRECT
        do_reset();
        redirect_ready = 1'b0;
        ws_ex = 1'b1;
        step();
        ws_ex = 1'b0;
        step();
        check_eq("arst_pre_rv", {31'b0, rv1}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check_eq("arst_flush", {31'b0, flush1}, 32'd0);
        check_eq("arst_rv", {31'b0, rv1}, 32'd0);
        check_eq("arst_int_req", {31'b0, int_req1}, 32'd0);
        check_eq("arst_busy", {31'b0, busy1}, 32'd0);
        check_eq("arst_pc", pc1, 32'h0);
        step();
        reset = 1'b0;
        redirect_ready = 1'b1;
        nrv = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (rv1 || busy1) nrv++;
        end
        check_eq("arst_no_redirect", nrv, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
